framebuffer_writer: RTL and testbench

// - Downstream of the triangle rasterizer: consumes its (x, y, drawing) pixel stream, clips to screen, computes the

---
 rtl/framebuffer_writer_if.sv | 31 +++
 rtl/framebuffer_writer.sv | 205 ++++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_if.sv
// Pixel-stream and memory-write signals between rasterizer, framebuffer_writer and the BRAM port.
// The slave modport is the writer's view; master is the surrounding rasterizer/memory side.
`timescale 1ns/1ps
interface framebuffer_writer_if #(
   parameter int COORD_WIDTH = 32,
   parameter int COLOR_WIDTH = 8,
   parameter int H_RES       = 320,
   parameter int V_RES       = 180
);
   localparam int ADDR_WIDTH = $clog2(H_RES * V_RES);

   logic                          pixel_valid;
   logic signed [COORD_WIDTH-1:0] pixel_x;
   logic signed [COORD_WIDTH-1:0] pixel_y;
   logic        [COLOR_WIDTH-1:0] pixel_color;
   logic                          pixel_ready;
   logic        [ADDR_WIDTH-1:0]  mem_addr;
   logic        [COLOR_WIDTH-1:0] mem_data;
   logic                          mem_we;
   logic                          mem_ready;

   modport master (
      output pixel_valid, pixel_x, pixel_y, pixel_color, mem_ready,
      input  pixel_ready, mem_addr, mem_data, mem_we
   );

   modport slave (
      input  pixel_valid, pixel_x, pixel_y, pixel_color, mem_ready,
      output pixel_ready, mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/framebuffer_writer.sv
// Clips rasterizer pixels, converts them to linear framebuffer addresses and queues BRAM writes;
// also fills the framebuffer on request. Optional clip statistics port under FBW_CLIP_STATS_EN.
`timescale 1ns/1ps
module framebuffer_writer #(
   parameter int COORD_WIDTH = 32,
   parameter int H_RES       = 320,
   parameter int V_RES       = 180,
   parameter int COLOR_WIDTH = 8,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   framebuffer_writer_if.slave    bus,
   input  logic                   clear_start,
   input  logic [COLOR_WIDTH-1:0] clear_color,
   output logic                   clear_busy,
   output logic                   clear_done,
`ifdef FBW_CLIP_STATS_EN
   output logic                   idle,
   output logic [15:0]            clip_count
`else
   output logic                   idle
`endif
);
   localparam int ADDR_WIDTH = $clog2(H_RES * V_RES);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   localparam logic signed [COORD_WIDTH-1:0] H_LIM     = COORD_WIDTH'(H_RES);
   localparam logic signed [COORD_WIDTH-1:0] V_LIM     = COORD_WIDTH'(V_RES);
   localparam logic [ADDR_WIDTH-1:0]         H_RES_A   = ADDR_WIDTH'(H_RES);
   localparam logic [ADDR_WIDTH-1:0]         LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
   localparam logic [PTR_W+1:0]              READY_LIM = (PTR_W + 2)'(FIFO_DEPTH - 2);

   typedef enum logic {S_RUN, S_CLEAR} state_e;

   state_e                 state_q, state_d;
   logic                   clear_pending_q, clear_pending_d;
   logic                   clear_done_q, clear_done_d;
   logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
   logic [COLOR_WIDTH-1:0] clr_color_q, clr_color_d;

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_clip_q, s1_clip_d;
   logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
   logic [COLOR_WIDTH-1:0] s1_color_q, s1_color_d;

   logic [ADDR_WIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  fifo_addr_d [FIFO_DEPTH];
   logic [COLOR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [COLOR_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         count_q, count_d;

   logic                   pix_rdy, accept, pix_clip, push, pop, fifo_empty;
   logic [ADDR_WIDTH-1:0]  pix_addr, x_lo, y_lo;
   logic [PTR_W+1:0]       occ;

   assign fifo_empty = (count_q == '0);
   assign accept     = bus.pixel_valid & pix_rdy;
   assign push       = s1_valid_q & ~s1_clip_q;
   assign pop        = (state_q == S_RUN) & ~fifo_empty & bus.mem_ready;
   assign occ        = (PTR_W + 2)'(count_q) + (PTR_W + 2)'(s1_valid_q);

   // Stage 1: clip test and address arithmetic on the incoming pixel.
   always_comb begin
      x_lo     = bus.pixel_x[ADDR_WIDTH-1:0];
      y_lo     = bus.pixel_y[ADDR_WIDTH-1:0];
      pix_addr = y_lo * H_RES_A + x_lo;
      pix_clip = bus.pixel_x[COORD_WIDTH-1] | (bus.pixel_x >= H_LIM) |
                 bus.pixel_y[COORD_WIDTH-1] | (bus.pixel_y >= V_LIM);

      s1_valid_d = accept;
      s1_clip_d  = s1_clip_q;
      s1_addr_d  = s1_addr_q;
      s1_color_d = s1_color_q;
      if (accept) begin
         s1_clip_d  = pix_clip;
         s1_addr_d  = pix_addr;
         s1_color_d = bus.pixel_color;
      end
   end

   // Stage 2: write FIFO; occupancy is bounded by pix_rdy so push never overflows.
   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = s1_addr_q;
         fifo_data_d[wr_ptr_q] = s1_color_q;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
   end

   // Next-state: a clear waits for the pixel path to drain, then sweeps every address.
   always_comb begin
      state_d         = state_q;
      clear_pending_d = clear_pending_q;
      clr_cnt_d       = clr_cnt_q;
      clr_color_d     = clr_color_q;
      clear_done_d    = 1'b0;
      case (state_q)
         S_RUN: begin
            if (clear_start && !clear_pending_q)
               clear_pending_d = 1'b1;
            if (clear_pending_q && fifo_empty && !s1_valid_q) begin
               state_d     = S_CLEAR;
               clr_cnt_d   = '0;
               clr_color_d = clear_color;
            end
         end
         S_CLEAR: begin
            if (bus.mem_ready) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d         = S_RUN;
                  clear_pending_d = 1'b0;
                  clear_done_d    = 1'b1;
               end else begin
                  clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q         <= S_RUN;
         clear_pending_q <= 1'b0;
         clear_done_q    <= 1'b0;
         clr_cnt_q       <= '0;
         clr_color_q     <= '0;
         s1_valid_q      <= 1'b0;
         s1_clip_q       <= 1'b0;
         s1_addr_q       <= '0;
         s1_color_q      <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         clear_pending_q <= clear_pending_d;
         clear_done_q    <= clear_done_d;
         clr_cnt_q       <= clr_cnt_d;
         clr_color_q     <= clr_color_d;
         s1_valid_q      <= s1_valid_d;
         s1_clip_q       <= s1_clip_d;
         s1_addr_q       <= s1_addr_d;
         s1_color_q      <= s1_color_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         fifo_addr_q     <= fifo_addr_d;
         fifo_data_q     <= fifo_data_d;
      end
   end

   // Outputs; pixel_ready is held low while reset is asserted.
   always_comb begin
      pix_rdy = rst_n_in & (state_q == S_RUN) & ~clear_pending_q & (occ <= READY_LIM);
      if (state_q == S_CLEAR) begin
         bus.mem_we   = 1'b1;
         bus.mem_addr = clr_cnt_q;
         bus.mem_data = clr_color_q;
      end else begin
         bus.mem_we   = ~fifo_empty;
         bus.mem_addr = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
         bus.mem_data = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
      end
      bus.pixel_ready = pix_rdy;
      clear_busy      = clear_pending_q | (state_q == S_CLEAR);
      clear_done      = clear_done_q;
      idle            = (state_q == S_RUN) & fifo_empty & ~s1_valid_q & ~clear_pending_q;
   end

`ifdef FBW_CLIP_STATS_EN
   logic [15:0] clip_cnt_q, clip_cnt_d;

   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (clear_done_d)
         clip_cnt_d = '0;
      else if (s1_valid_q && s1_clip_q && clip_cnt_q != 16'hFFFF)
         clip_cnt_d = clip_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) clip_cnt_q <= '0;
      else           clip_cnt_q <= clip_cnt_d;
   end

   assign clip_count = clip_cnt_q;
`else
`endif
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed and randomized checks of framebuffer_writer against a queue-based write-order model.
`timescale 1ns/1ps
module tb_framebuffer_writer;
   localparam int HR = 320;
   localparam int VR = 180;
   localparam int NPIX = HR * VR;

   logic       clk_in, rst_n_in;
   logic       clear_start;
   logic [7:0] clear_color;
   logic       clear_busy, clear_done, idle;
`ifdef FBW_CLIP_STATS_EN
   logic [15:0] clip_count;
`endif

   framebuffer_writer_if #(.COORD_WIDTH(32), .COLOR_WIDTH(8), .H_RES(HR), .V_RES(VR)) bus ();

   framebuffer_writer #(.COORD_WIDTH(32), .H_RES(HR), .V_RES(VR), .COLOR_WIDTH(8), .FIFO_DEPTH(8)) dut (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .bus         (bus),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
`ifdef FBW_CLIP_STATS_EN
      .idle        (idle),
      .clip_count  (clip_count)
`else
      .idle        (idle)
`endif
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int tests = 0;
   int fails = 0;

   // Model state: expected writes in acceptance order, observed writes, event counters.
   logic [23:0] expq[$];
   logic [23:0] obs[$];
   int acc_cnt = 0, clip_exp = 0, done_cnt = 0, busy_rdy_cnt = 0;

   always @(negedge clk_in) begin
      if (rst_n_in && bus.pixel_valid && bus.pixel_ready) begin
         int xi, yi;
         xi = bus.pixel_x;
         yi = bus.pixel_y;
         acc_cnt++;
         if (xi >= 0 && xi < HR && yi >= 0 && yi < VR)
            expq.push_back({16'(yi * HR + xi), bus.pixel_color});
         else
            clip_exp++;
      end
      if (bus.mem_we && bus.mem_ready) obs.push_back({bus.mem_addr, bus.mem_data});
      if (clear_done) done_cnt++;
      if (clear_busy && bus.pixel_ready) busy_rdy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive_px(input logic v, input int x, input int y, input logic [7:0] c);
      bus.pixel_valid = v;
      bus.pixel_x     = x;
      bus.pixel_y     = y;
      bus.pixel_color = c;
   endtask

   initial begin
      int n, bad, cyc;
      rst_n_in = 1'b0; clear_start = 1'b0; clear_color = '0; bus.mem_ready = 1'b1;
      drive_px(1'b0, 0, 0, 8'h00);

      // Reset state
      tick(); tick();
      check("rst_pixel_ready", bus.pixel_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_data", bus.mem_data, 0);
      check("rst_clear_busy", clear_busy, 0);
      check("rst_clear_done", clear_done, 0);
      rst_n_in = 1'b1;
      #1;
      check("post_rst_ready", bus.pixel_ready, 1);
      check("post_rst_idle", idle, 1);

      // Single pixel latency
      obs.delete(); expq.delete();
      drive_px(1'b1, 10, 20, 8'h5A);
      check("lat_ready_n", bus.pixel_ready, 1);
      tick();
      drive_px(1'b0, 0, 0, 8'h00);
      check("lat_we_n1", bus.mem_we, 0);
      tick();
      check("lat_we_n2", bus.mem_we, 1);
      check("lat_addr", bus.mem_addr, 6410);
      check("lat_data", bus.mem_data, 8'h5A);
      repeat (3) tick();
      check("lat_one_write", obs.size(), 1);
      check("lat_we_after", bus.mem_we, 0);

      // Clipped pixels
      obs.delete(); expq.delete();
      drive_px(1'b1, -1, 5, 8'h01);   tick();
      drive_px(1'b1, 320, 0, 8'h02);  tick();
      drive_px(1'b1, 0, 180, 8'h03);  tick();
      drive_px(1'b0, 0, 0, 8'h00);
      repeat (4) tick();
      check("clip_no_write", obs.size(), 0);
      check("clip_model_cnt", clip_exp, 3);
`ifdef FBW_CLIP_STATS_EN
      check("clip_count3", clip_count, 3);
`endif

      // Backpressure: stream with mem_ready low
      obs.delete(); expq.delete(); acc_cnt = 0;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive_px(1'b1, 30 + i, 7, 8'(i + 1));
         tick();
      end
      drive_px(1'b0, 0, 0, 8'h00);
      check("stall_ready_low", bus.pixel_ready, 0);
      check("stall_we_held", bus.mem_we, 1);
      check("stall_no_xfer", obs.size(), 0);
      check("stall_accepts_range", (acc_cnt >= 6 && acc_cnt <= 7), 1);
      bus.mem_ready = 1'b1;
      repeat (12) tick();
      check("stall_wr_count", obs.size(), acc_cnt);
      n = (obs.size() < expq.size()) ? obs.size() : expq.size();
      for (int i = 0; i < n; i++) check("stall_wr_order", obs[i], expq[i]);

      // Randomized stream against the model
      obs.delete(); expq.delete();
      for (int i = 0; i < 400; i++) begin
         drive_px($urandom_range(0, 3) != 0, int'($urandom_range(0, 359)) - 20,
                  int'($urandom_range(0, 219)) - 20, 8'($urandom));
         bus.mem_ready = $urandom_range(0, 1) == 1;
         tick();
      end
      drive_px(1'b0, 0, 0, 8'h00);
      bus.mem_ready = 1'b1;
      cyc = 0;
      while (!idle && cyc < 200) begin tick(); cyc++; end
      check("rand_drained", idle, 1);
      check("rand_wr_count", obs.size(), expq.size());
      n = (obs.size() < expq.size()) ? obs.size() : expq.size();
      bad = 0;
      for (int i = 0; i < n; i++) if (obs[i] !== expq[i]) bad++;
      check("rand_wr_mismatches", bad, 0);
`ifdef FBW_CLIP_STATS_EN
      check("rand_clip_count", clip_count, clip_exp);
`endif

      // Clear with queued pixels, one of them accepted alongside clear_start
      obs.delete(); expq.delete(); done_cnt = 0; busy_rdy_cnt = 0;
      bus.mem_ready = 1'b0;
      drive_px(1'b1, 1, 1, 8'h21); tick();
      drive_px(1'b1, 2, 3, 8'h22); tick();
      drive_px(1'b1, 5, 5, 8'h55);
      clear_start = 1'b1; clear_color = 8'hC3;
      check("clr_same_cycle_ready", bus.pixel_ready, 1);
      tick();
      drive_px(1'b0, 0, 0, 8'h00);
      clear_start = 1'b0;
      check("clr_busy_set", clear_busy, 1);
      check("clr_ready_drop", bus.pixel_ready, 0);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      bus.mem_ready = 1'b1;
      cyc = 0;
      while (done_cnt == 0 && cyc < 60000) begin tick(); cyc++; end
      repeat (3) tick();
      check("clr_done_once", done_cnt, 1);
      check("clr_not_requeued", clear_busy, 0);
      check("clr_idle", idle, 1);
      check("clr_ready_while_busy", busy_rdy_cnt, 0);
      check("clr_pix_expected", expq.size(), 3);
      check("clr_wr_total", obs.size(), 3 + NPIX);
      if (obs.size() == 3 + NPIX && expq.size() == 3) begin
         for (int i = 0; i < 3; i++) check("clr_pix_first", obs[i], expq[i]);
         check("clr_last_pix_1605", obs[2], {16'd1605, 8'h55});
         bad = 0;
         for (int i = 0; i < NPIX; i++) if (obs[3 + i] !== {16'(i), 8'hC3}) bad++;
         check("clr_sweep_mismatches", bad, 0);
      end
`ifdef FBW_CLIP_STATS_EN
      check("clr_clip_zeroed", clip_count, 0);
`endif

      // Reset in the middle of a clear
      obs.delete(); done_cnt = 0;
      clear_start = 1'b1; clear_color = 8'h3C;
      tick();
      clear_start = 1'b0;
      cyc = 0;
      while (!(bus.mem_we && clear_busy && bus.mem_addr == 16'd1000) && cyc < 3000) begin
         tick(); cyc++;
      end
      check("mid_reached_1000", bus.mem_addr, 1000);
      rst_n_in = 1'b0;
      #1;
      check("mid_rst_ready_low", bus.pixel_ready, 0);
      tick();
      check("mid_rst_we", bus.mem_we, 0);
      check("mid_rst_busy", clear_busy, 0);
      check("mid_rst_done", clear_done, 0);
      rst_n_in = 1'b1;
      tick();
      check("mid_idle", idle, 1);
      check("mid_we_after", bus.mem_we, 0);
      repeat (3) tick();
      check("mid_no_done", done_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
